// File: rtl/adder_arbiter.sv
// Round-robin arbiter that shares one pipelined I/Q adder between N_REQ requesters,
// returning each sum to its issuer and flushing the adder after every system reset.
module adder_arbiter #(
  parameter int N_REQ        = 4,
  parameter int ADD_LATENCY  = 2,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic                 M100CLK,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_i,
  input  logic [32*N_REQ-1:0]  req_q,
  output logic                 adder_rst,
  output logic [31:0]          adder_i,
  output logic [31:0]          adder_q,
  input  logic [32:0]          adder_sum,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [32:0]          rsp_sum,
  output logic                 busy
);

  localparam int RW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int PD = ADD_LATENCY + 1;
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {FLUSH, WAKE, RUN} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   flush_cnt, flush_cnt_nxt;
  logic [RW-1:0]   rr_ptr;
  logic [RW-1:0]   grant_idx;
  logic            grant_any;
  logic            xfer;
  logic [PD-1:0]   pipe_valid;
  logic [RW-1:0]   pipe_tag [PD];

  function automatic logic [RW-1:0] wrap_add(input logic [RW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return RW'(s);
  endfunction

  always_ff @(posedge M100CLK or negedge reset) begin
    if (!reset) begin
      state     <= FLUSH;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    adder_rst     = 1'b0;
    unique case (state)
      FLUSH: begin
        adder_rst = 1'b1;
        if (flush_cnt == CW'(FLUSH_CYCLES - 1)) state_nxt = WAKE;
        else flush_cnt_nxt = flush_cnt + 1'b1;
      end
      // One idle cycle lets the adder's registered internal reset clear.
      WAKE:    state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = FLUSH;
    endcase
  end

  always_comb begin
    grant_any = 1'b0;
    grant_idx = rr_ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_any && req_valid[wrap_add(rr_ptr, i)]) begin
        grant_any = 1'b1;
        grant_idx = wrap_add(rr_ptr, i);
      end
    end
  end

  assign xfer = (state == RUN) && grant_any;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[grant_idx] = 1'b1;
  end

  // Tag stage 0 loads alongside adder_i; the last stage lines up with a valid adder_sum.
  always_ff @(posedge M100CLK or negedge reset) begin
    if (!reset) begin
      rr_ptr     <= '0;
      adder_i    <= '0;
      adder_q    <= '0;
      pipe_valid <= '0;
      for (int s = 0; s < PD; s++) pipe_tag[s] <= '0;
      rsp_valid  <= '0;
      rsp_sum    <= '0;
    end else begin
      if (xfer) begin
        adder_i <= req_i[int'(grant_idx)*32 +: 32];
        adder_q <= req_q[int'(grant_idx)*32 +: 32];
        rr_ptr  <= wrap_add(grant_idx, 1);
      end
      pipe_valid[0] <= xfer;
      pipe_tag[0]   <= grant_idx;
      for (int s = 1; s < PD; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        pipe_tag[s]   <= pipe_tag[s-1];
      end
      if (pipe_valid[PD-1]) begin
        rsp_valid <= ONE_HOT0 << pipe_tag[PD-1];
        rsp_sum   <= adder_sum;
      end else begin
        rsp_valid <= '0;
      end
    end
  end

  assign busy = (state != RUN) || (|pipe_valid);

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a two-stage behavioural adder behind it.
module tb_adder_arbiter;

  logic         M100CLK;
  logic         reset;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_i;
  logic [127:0] req_q;
  logic         adder_rst;
  logic [31:0]  adder_i;
  logic [31:0]  adder_q;
  logic [32:0]  adder_sum;
  logic [3:0]   rsp_valid;
  logic [32:0]  rsp_sum;
  logic         busy;

  logic [31:0]  di [4];
  logic [31:0]  dq [4];
  logic [32:0]  add_s1;
  int           total;
  int           bad;

  adder_arbiter #(.N_REQ(4), .ADD_LATENCY(2), .FLUSH_CYCLES(3)) dut (
    .M100CLK(M100CLK), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_i(req_i), .req_q(req_q),
    .adder_rst(adder_rst), .adder_i(adder_i), .adder_q(adder_q), .adder_sum(adder_sum),
    .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .busy(busy)
  );

  initial M100CLK = 1'b0;
  always #5 M100CLK = ~M100CLK;

  for (genvar k = 0; k < 4; k++) begin : g_pack
    assign req_i[32*k +: 32] = di[k];
    assign req_q[32*k +: 32] = dq[k];
  end

  // Adder stand-in: samples operands one edge after they are registered, sum valid one edge later.
  always @(posedge M100CLK) begin
    if (adder_rst) begin
      add_s1    <= '0;
      adder_sum <= '0;
    end else begin
      add_s1    <= {adder_i[31], adder_i} + {adder_q[31], adder_q};
      adder_sum <= add_s1;
    end
  end

  task automatic test_reset;
    req_valid = 4'hF;
    #1;
    total++; if (req_ready !== 4'h0)  begin bad++; $display("FAIL reset_ready got=%h want=%h", req_ready, 4'h0); end
    total++; if (rsp_valid !== 4'h0)  begin bad++; $display("FAIL reset_rsp_valid got=%h want=%h", rsp_valid, 4'h0); end
    total++; if (rsp_sum !== 33'h0)   begin bad++; $display("FAIL reset_rsp_sum got=%h want=%h", rsp_sum, 33'h0); end
    total++; if (adder_rst !== 1'b1)  begin bad++; $display("FAIL reset_adder_rst got=%b want=%b", adder_rst, 1'b1); end
    total++; if (adder_i !== 32'h0)   begin bad++; $display("FAIL reset_adder_i got=%h want=%h", adder_i, 32'h0); end
    total++; if (adder_q !== 32'h0)   begin bad++; $display("FAIL reset_adder_q got=%h want=%h", adder_q, 32'h0); end
    total++; if (busy !== 1'b1)       begin bad++; $display("FAIL reset_busy got=%b want=%b", busy, 1'b1); end
    @(negedge M100CLK);
  endtask

  task automatic test_flush;
    reset = 1'b1;
    #1;
    total++; if (adder_rst !== 1'b1) begin bad++; $display("FAIL flush0_adder_rst got=%b want=%b", adder_rst, 1'b1); end
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL flush0_ready got=%h want=%h", req_ready, 4'h0); end
    for (int n = 1; n <= 2; n++) begin
      @(negedge M100CLK); #1;
      total++; if (adder_rst !== 1'b1) begin bad++; $display("FAIL flush%0d_adder_rst got=%b want=%b", n, adder_rst, 1'b1); end
      total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL flush%0d_ready got=%h want=%h", n, req_ready, 4'h0); end
    end
    @(negedge M100CLK); #1;
    total++; if (adder_rst !== 1'b0) begin bad++; $display("FAIL wake_adder_rst got=%b want=%b", adder_rst, 1'b0); end
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL wake_ready got=%h want=%h", req_ready, 4'h0); end
    total++; if (busy !== 1'b1)      begin bad++; $display("FAIL wake_busy got=%b want=%b", busy, 1'b1); end
    @(negedge M100CLK); #1;
    total++; if (req_ready !== 4'h1) begin bad++; $display("FAIL run_first_grant got=%h want=%h", req_ready, 4'h1); end
    total++; if (adder_rst !== 1'b0) begin bad++; $display("FAIL run_adder_rst got=%b want=%b", adder_rst, 1'b0); end
    req_valid = 4'h0;
    #1;
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL run_idle_ready got=%h want=%h", req_ready, 4'h0); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL run_idle_busy got=%b want=%b", busy, 1'b0); end
    @(negedge M100CLK);
  endtask

  task automatic test_back_to_back;
    logic [3:0]  exp_rv;
    logic [3:0]  exp_rdy;
    logic [32:0] sums [4];
    sums = '{33'h0_0000_0011, 33'h0_0000_0300, 33'h0_0000_0002, 33'h1_FFFF_FFFE};
    di = '{32'h0000_0010, 32'h0000_0100, 32'h0000_0005, 32'hFFFF_FFFF};
    dq = '{32'h0000_0001, 32'h0000_0200, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    for (int c = 0; c < 13; c++) begin
      exp_rv = (c >= 4 && c < 12) ? 4'(1 << ((c - 4) % 4)) : 4'h0;
      total++; if (rsp_valid !== exp_rv) begin bad++; $display("FAIL b2b_rsp_valid c=%0d got=%h want=%h", c, rsp_valid, exp_rv); end
      if (c >= 4 && c < 12) begin
        total++; if (rsp_sum !== sums[(c-4)%4]) begin bad++; $display("FAIL b2b_rsp_sum c=%0d got=%h want=%h", c, rsp_sum, sums[(c-4)%4]); end
      end
      if (c >= 1 && c <= 8) begin
        total++; if (adder_i !== di[(c-1)%4]) begin bad++; $display("FAIL b2b_adder_i c=%0d got=%h want=%h", c, adder_i, di[(c-1)%4]); end
      end
      req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      exp_rdy = (c < 8) ? 4'(1 << (c % 4)) : 4'h0;
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL b2b_ready c=%0d got=%h want=%h", c, req_ready, exp_rdy); end
      @(negedge M100CLK);
    end
  endtask

  task automatic test_single;
    di[2] = 32'h0000_0005;
    dq[2] = 32'hFFFF_FFFD;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) begin
        total++; if (rsp_valid !== 4'b0100) begin bad++; $display("FAIL single_rsp_valid got=%h want=%h", rsp_valid, 4'b0100); end
        total++; if (rsp_sum !== 33'h0_0000_0002) begin bad++; $display("FAIL single_rsp_sum got=%h want=%h", rsp_sum, 33'h0_0000_0002); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_drained got=%b want=%b", busy, 1'b0); end
      end else begin
        total++; if (rsp_valid !== 4'h0) begin bad++; $display("FAIL single_rsp_idle c=%0d got=%h want=%h", c, rsp_valid, 4'h0); end
      end
      if (c == 1) begin
        total++; if (adder_i !== 32'h0000_0005) begin bad++; $display("FAIL single_adder_i got=%h want=%h", adder_i, 32'h0000_0005); end
        total++; if (adder_q !== 32'hFFFF_FFFD) begin bad++; $display("FAIL single_adder_q got=%h want=%h", adder_q, 32'hFFFF_FFFD); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=%b", busy, 1'b1); end
      end
      req_valid = (c == 0) ? 4'b0100 : 4'h0;
      #1;
      total++; if (req_ready !== req_valid) begin bad++; $display("FAIL single_ready c=%0d got=%h want=%h", c, req_ready, req_valid); end
      @(negedge M100CLK);
    end
  endtask

  task automatic test_extremes;
    logic [3:0]  vtab [7];
    logic [3:0]  gtab [7];
    logic [3:0]  rtab [7];
    vtab = '{4'b0011, 4'b0010, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    gtab = '{4'b0001, 4'b0010, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    rtab = '{4'h0, 4'h0, 4'h0, 4'h0, 4'b0001, 4'b0010, 4'h0};
    di[0] = 32'h7FFF_FFFF; dq[0] = 32'h0000_0001;
    di[1] = 32'h8000_0000; dq[1] = 32'h8000_0000;
    for (int c = 0; c < 7; c++) begin
      total++; if (rsp_valid !== rtab[c]) begin bad++; $display("FAIL ext_rsp_valid c=%0d got=%h want=%h", c, rsp_valid, rtab[c]); end
      if (c == 4) begin
        total++; if (rsp_sum !== 33'h0_8000_0000) begin bad++; $display("FAIL ext_pos_overflow got=%h want=%h", rsp_sum, 33'h0_8000_0000); end
      end
      if (c >= 5) begin
        total++; if (rsp_sum !== 33'h1_0000_0000) begin bad++; $display("FAIL ext_neg_overflow c=%0d got=%h want=%h", c, rsp_sum, 33'h1_0000_0000); end
      end
      req_valid = vtab[c];
      #1;
      total++; if (req_ready !== gtab[c]) begin bad++; $display("FAIL ext_ready c=%0d got=%h want=%h", c, req_ready, gtab[c]); end
      @(negedge M100CLK);
    end
  endtask

  task automatic test_wrap;
    logic [3:0]  vtab [11];
    logic [3:0]  gtab [11];
    logic [3:0]  rtab [11];
    logic [32:0] stab [11];
    vtab = '{4'b0001, 4'b1000, 4'b1000, 4'b1000, 4'b1010, 4'b1010, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    gtab = '{4'b0001, 4'b1000, 4'b1000, 4'b1000, 4'b0010, 4'b1000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    rtab = '{4'h0, 4'h0, 4'h0, 4'h0, 4'b0001, 4'b1000, 4'b1000, 4'b1000, 4'b0010, 4'b1000, 4'h0};
    stab = '{33'h0, 33'h0, 33'h0, 33'h0, 33'h0_0000_0003, 33'h0_0000_1244, 33'h0_0000_1244,
             33'h0_0000_1244, 33'h0_0000_0010, 33'h0_0000_1244, 33'h0};
    di[0] = 32'h0000_0001; dq[0] = 32'h0000_0002;
    di[1] = 32'hFFFF_FFF0; dq[1] = 32'h0000_0020;
    di[3] = 32'h0000_1234; dq[3] = 32'h0000_0010;
    for (int c = 0; c < 11; c++) begin
      total++; if (rsp_valid !== rtab[c]) begin bad++; $display("FAIL wrap_rsp_valid c=%0d got=%h want=%h", c, rsp_valid, rtab[c]); end
      if (rtab[c] != 4'h0) begin
        total++; if (rsp_sum !== stab[c]) begin bad++; $display("FAIL wrap_rsp_sum c=%0d got=%h want=%h", c, rsp_sum, stab[c]); end
      end
      req_valid = vtab[c];
      #1;
      total++; if (req_ready !== gtab[c]) begin bad++; $display("FAIL wrap_ready c=%0d got=%h want=%h", c, req_ready, gtab[c]); end
      @(negedge M100CLK);
    end
  endtask

  task automatic test_mid_reset;
    logic [3:0] exp_rdy;
    di[0] = 32'h0000_0111; dq[0] = 32'h0000_0001;
    di[1] = 32'h0000_0222; dq[1] = 32'h0000_0002;
    req_valid = 4'b0001;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mrst_grant0 got=%h want=%h", req_ready, 4'b0001); end
    @(negedge M100CLK);
    req_valid = 4'b0010;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL mrst_grant1 got=%h want=%h", req_ready, 4'b0010); end
    @(negedge M100CLK);
    total++; if (adder_i !== 32'h0000_0222) begin bad++; $display("FAIL mrst_pre_adder_i got=%h want=%h", adder_i, 32'h0000_0222); end
    req_valid = 4'h0;
    reset = 1'b0;
    #1;
    total++; if (adder_rst !== 1'b1)  begin bad++; $display("FAIL mrst_adder_rst got=%b want=%b", adder_rst, 1'b1); end
    total++; if (adder_i !== 32'h0)   begin bad++; $display("FAIL mrst_adder_i got=%h want=%h", adder_i, 32'h0); end
    total++; if (adder_q !== 32'h0)   begin bad++; $display("FAIL mrst_adder_q got=%h want=%h", adder_q, 32'h0); end
    total++; if (rsp_sum !== 33'h0)   begin bad++; $display("FAIL mrst_rsp_sum got=%h want=%h", rsp_sum, 33'h0); end
    total++; if (busy !== 1'b1)       begin bad++; $display("FAIL mrst_busy got=%b want=%b", busy, 1'b1); end
    @(negedge M100CLK);
    reset = 1'b1;
    req_valid = 4'hF;
    for (int n = 0; n < 6; n++) begin
      #1;
      total++; if (rsp_valid !== 4'h0) begin bad++; $display("FAIL mrst_no_rsp n=%0d got=%h want=%h", n, rsp_valid, 4'h0); end
      total++; if (rsp_sum !== 33'h0)  begin bad++; $display("FAIL mrst_rsp_sum_hold n=%0d got=%h want=%h", n, rsp_sum, 33'h0); end
      total++; if (adder_rst !== (n < 3)) begin bad++; $display("FAIL mrst_flush n=%0d got=%b want=%b", n, adder_rst, (n < 3)); end
      exp_rdy = (n == 4) ? 4'b0001 : (n == 5) ? 4'b0010 : 4'h0;
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL mrst_ready n=%0d got=%h want=%h", n, req_ready, exp_rdy); end
      @(negedge M100CLK);
    end
    req_valid = 4'h0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    req_valid = 4'h0;
    for (int k = 0; k < 4; k++) begin
      di[k] = 32'h0;
      dq[k] = 32'h0;
    end
    #2 reset = 1'b0;
    @(negedge M100CLK);
    test_reset();
    test_flush();
    test_back_to_back();
    test_single();
    test_extremes();
    test_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
Round-robin arbiter and sequencer that shares one pipelined I/Q Adder between N_REQ requesters in the DRFM datapath. It accepts I/Q pairs over valid/ready handshakes and drives the Adder's inputs and its active-high reset. It tracks each in-flight operation with a latency-matched tag pipeline and returns every 33-bit sum to the requester that issued it. It also runs the Adder's reset/flush sequence after system reset so that no stale pipeline data reaches a requester.

Parameters:
N_REQ, 4, number of requesters (2..8); index width RW = clog2(N_REQ)
ADD_LATENCY, 2, Adder clock edges from input sample to valid sum output
FLUSH_CYCLES, 3, cycles adder_rst is held high after reset release (minimum 1)

Ports:
M100CLK  input  1  system clock, 100 MHz; all logic on rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  N_REQ  per-requester request valid
req_ready  output  N_REQ  per-requester accept, one-hot or zero
req_i  input  32*N_REQ  packed I samples, 2's complement; requester k at bits [32k+31:32k]
req_q  input  32*N_REQ  packed Q samples, 2's complement, same packing
adder_rst  output  1  active-high reset to the Adder
adder_i  output  32  Adder I operand (registered)
adder_q  output  32  Adder Q operand (registered)
adder_sum  input  33  Adder result, 2's complement
rsp_valid  output  N_REQ  one-hot, single-cycle result strobe
rsp_sum  output  33  result for the requester flagged in rsp_valid
busy  output  1  high while any operation is in flight or state is not RUN

Behaviour:
- Reset low (asynchronous) forces: state=FLUSH, flush_cnt=0, rr_ptr=0, all tag-pipe valids=0, adder_rst=1, adder_i=0, adder_q=0, req_ready=0, rsp_valid=0, rsp_sum=0, busy=1.
- State machine (FSM):
  - FLUSH: adder_rst=1. flush_cnt increments each cycle. At flush_cnt==FLUSH_CYCLES-1 → WAKE.
  - WAKE: adder_rst=0 for exactly 1 cycle. This covers the Adder's registered internal reset. → RUN.
  - RUN: adder_rst=0. Arbitration is enabled. The FSM stays in RUN until the next reset.
- req_ready is combinational and nonzero only in RUN.
- Arbitration: scan indices rr_ptr, rr_ptr+1, ... modulo N_REQ. The first index k with req_valid[k]=1 gets req_ready[k]=1.
- req_ready is never asserted to a requester whose req_valid is 0.
- At most one transfer per cycle. A transfer occurs when req_valid[k] & req_ready[k].
- On a transfer to requester k:
  - adder_i←req_i[k], adder_q←req_q[k], rr_ptr←(k+1) mod N_REQ.
  - Push {valid=1, tag=k} into the tag pipe.
- On a cycle with no transfer:
  - adder_i and adder_q hold their values; rr_ptr holds.
  - Push valid=0 into the tag pipe.
- Tag pipe depth is ADD_LATENCY+1. The stage-0 push aligns with the adder_i register.
- The pipe output at stage ADD_LATENCY+1 registers rsp_valid[tag]=1 and rsp_sum←adder_sum.
- Latency: a transfer at clock edge E0 produces rsp_valid/rsp_sum visible after edge E0+ADD_LATENCY+1, i.e. 3 cycles at default.
- Throughput is 1 op/cycle. Responses return in issue order.
- rsp_valid is high for exactly one cycle and there is no backpressure. rsp_sum holds its last value when rsp_valid=0.
- Width: rsp_sum is adder_sum passed through unmodified, 33-bit 2's complement. No truncation or saturation is applied here.
- busy = (state!=RUN) | any tag-pipe valid.
- Boundary conditions:
  - Requester k is granted and another requester j asserts valid in the same cycle: j waits. The next scan starts at k+1, so each requester waits at most N_REQ-1 grants.
  - A requester holding valid while not granted must keep req_i/req_q stable. Unaccepted data is never sampled.
  - rr_ptr wraps from N_REQ-1 to 0.
  - A requester's response cycle coincides with a new request from it: both proceed independently.
  - Reset asserted mid-operation: in-flight ops are discarded and no rsp_valid is produced for them. After reset release the full FLUSH/WAKE sequence repeats.

Test Plan:
- Reset release, req_valid=all ones → adder_rst=1 for 3 cycles, then 1 WAKE cycle with no req_ready, then the first grant goes to req 0.
- Single request, req 2: I=0x0000_0005, Q=0xFFFF_FFFD (−3), accepted at E0 → rsp_valid=4'b0100, rsp_sum=33'h0_0000_0002 after E3; no other rsp_valid pulses.
- All 4 requesters valid continuously for 8 cycles → grants 0,1,2,3,0,1,2,3, one per cycle. Responses follow 3 cycles later in the same order with the correct per-requester sums.
- Req 0: I=0x7FFF_FFFF, Q=0x0000_0001 → rsp_sum=33'h0_8000_0000. Req 1: I=0x8000_0000, Q=0x8000_0000 → rsp_sum=33'h1_0000_0000.
- Req 3 valid alone for 3 cycles while rr_ptr=1 → granted every cycle, rr_ptr wraps to 0. Req 1 then asserts valid → req 1 is granted before req 3 is granted again.
- Reset pulsed low 1 cycle after 2 ops are accepted → all outputs return to reset values immediately, no rsp_valid for those ops, and the FLUSH sequence restarts.
